qspi_pin_arbiter: RTL

- Sequences ownership of the four shared QSPI data pins between the flash controller and the software GPIO path.
- Software requests pins through the GPIO block's per-channel master_control bits.
- The arbiter holds off the flash controller, waits for the bus to go idle, tristates the pins for a guard interval, then hands the pins over. It reverses the sequence when software releases them.
- Sits between the GPIO MMIO block, the flash controller and the pad mux.

---
 rtl/qspi_arb_pkg.sv | 15 +
 rtl/qspi_arb_timer.sv | 34 +++
 rtl/qspi_pin_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/qspi_arb_pkg.sv
// rtl/qspi_arb_pkg.sv - shared types and widths for the QSPI pin arbiter
package qspi_arb_pkg;

  localparam int ARB_STATE_W    = 3;
  localparam int HANDOVER_CNT_W = 8;

  typedef enum logic [ARB_STATE_W-1:0] {
    ST_FLASH_OWN = 3'd0,
    ST_DRAIN     = 3'd1,
    ST_GUARD     = 3'd2,
    ST_GPIO_OWN  = 3'd3,
    ST_RGUARD    = 3'd4
  } arb_state_e;

endpackage

// File: rtl/qspi_arb_timer.sv
// rtl/qspi_arb_timer.sv - loadable down-counter that saturates at zero
module qspi_arb_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/qspi_pin_arbiter.sv
// rtl/qspi_pin_arbiter.sv - hands the four QSPI data pins between flash and GPIO
module qspi_pin_arbiter
  import qspi_arb_pkg::*;
#(
  parameter int GUARD_CYCLES  = 4,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                      soc_clk,
  input  logic                      rst,
  input  logic [3:0]                sw_master_req,
  input  logic                      flash_busy,
  input  logic                      flash_csb_out,
  input  logic                      clr_timeout,
  output logic [3:0]                pin_owner,
  output logic                      pad_oe_kill,
  output logic                      flash_hold,
  output logic [ARB_STATE_W-1:0]    arb_state,
  output logic                      drain_timeout,
  output logic [HANDOVER_CNT_W-1:0] handover_cnt
);

  localparam int GW = 8;
  localparam int DW = $clog2(DRAIN_TIMEOUT);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_TIMEOUT - 1);

  arb_state_e                state_q, state_d;
  logic [3:0]                owner_q, owner_d;
  logic [HANDOVER_CNT_W-1:0] cnt_q, cnt_d;
  logic                      timeout_q, timeout_d;

  logic            req_any, flash_idle, drain_set;
  logic            guard_load, guard_dec, guard_zero;
  logic            drain_load, drain_dec, drain_zero;
  logic [DW-1:0]   drain_val;

  assign req_any    = |sw_master_req;
  assign flash_idle = !flash_busy && flash_csb_out;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    drain_set = 1'b0;
    unique case (state_q)
      ST_FLASH_OWN: begin
        if (req_any) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!req_any) begin
          state_d = ST_FLASH_OWN;
        end else if (flash_idle) begin
          state_d = ST_GUARD;
        end else if (drain_zero) begin
          drain_set = 1'b1;
        end
      end
      ST_GUARD: begin
        if (guard_zero) begin
          if (req_any) begin
            state_d = ST_GPIO_OWN;
            owner_d = sw_master_req;
            cnt_d   = cnt_q + 1'b1;
          end else begin
            state_d = ST_RGUARD;
          end
        end
      end
      ST_GPIO_OWN: begin
        if (!req_any) begin
          state_d = ST_RGUARD;
        end else if (sw_master_req != owner_q) begin
          state_d = ST_GUARD;
        end
      end
      ST_RGUARD: begin
        // A fresh request goes straight back to GUARD: flash is still held.
        if (req_any) begin
          state_d = ST_GUARD;
        end else if (guard_zero) begin
          state_d = ST_FLASH_OWN;
        end
      end
      default: state_d = ST_FLASH_OWN;
    endcase
  end

  assign guard_load = ((state_d == ST_GUARD)  && (state_q != ST_GUARD)) ||
                      ((state_d == ST_RGUARD) && (state_q != ST_RGUARD));
  assign guard_dec  = !guard_load;

  // Drain count is held as "cycles remaining"; zero means the limit is reached.
  assign drain_load = (state_q != ST_DRAIN) || (state_d != ST_DRAIN);
  assign drain_val  = (state_d == ST_DRAIN) ? DRAIN_LOAD : '0;
  assign drain_dec  = !drain_load;

  assign timeout_d = drain_set ? 1'b1 : (clr_timeout ? 1'b0 : timeout_q);

  qspi_arb_timer #(.W(GW)) u_guard_timer (
    .clk        (soc_clk),
    .rst        (rst),
    .load_i     (guard_load),
    .load_val_i (GUARD_LOAD),
    .dec_i      (guard_dec),
    .zero_o     (guard_zero)
  );

  qspi_arb_timer #(.W(DW)) u_drain_timer (
    .clk        (soc_clk),
    .rst        (rst),
    .load_i     (drain_load),
    .load_val_i (drain_val),
    .dec_i      (drain_dec),
    .zero_o     (drain_zero)
  );

  always_ff @(posedge soc_clk) begin
    if (rst) begin
      state_q   <= ST_FLASH_OWN;
      owner_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign arb_state     = state_q;
  assign pin_owner     = (state_q == ST_GPIO_OWN) ? owner_q : 4'b0000;
  assign pad_oe_kill   = (state_q == ST_GUARD) || (state_q == ST_RGUARD);
  assign flash_hold    = (state_q != ST_FLASH_OWN);
  assign drain_timeout = timeout_q;
  assign handover_cnt  = cnt_q;

endmodule
